// File: rtl/control_sequencer.sv
// control_sequencer: one-hot T-step sequencer with stall, stop, HALT/resume and optional
// interrupt entry (INT0/INT1), enabled by defining CTRL_INTR_EN.
module control_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int STEP_COUNT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stop,
    input  logic                  stall,
    input  logic                  resume,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  int_req,
    input  logic                  int_mask,
    output logic [STEP_COUNT-1:0] step,
    output logic [1:0]            int_seq,
    output logic                  run,
    output logic                  clear,
    output logic                  halted,
    output logic                  int_ack,
    output logic                  instr_done
);
    localparam int IW = $clog2(STEP_COUNT);
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {CLR, EXEC, INT0, INT1, HALTED} state_t;

    state_t        state, nstate;
    logic [IW-1:0] idx, nidx, last;
    logic [4:0]    opcode;
    logic          irq, at_last, unused_ir;

    assign opcode    = IR[DATA_WIDTH-1 -: 5];
    assign unused_ir = ^IR[DATA_WIDTH-6:0];

`ifdef CTRL_INTR_EN
    assign irq = int_req & ~int_mask;
`else
    logic unused_int;
    assign irq        = 1'b0;
    assign unused_int = int_req ^ int_mask;
`endif

    // Last T-step of each opcode; fetch (T0-T2) always runs in full.
    always_comb begin
        last = IW'(5);
        case (opcode)
            5'b00000, 5'b00010:                                     last = IW'(7);
            5'b01111, 5'b10000, 5'b10011:                           last = IW'(6);
            5'b10001, 5'b10010, 5'b10101:                           last = IW'(4);
            5'b10100, 5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11011: last = IW'(3);
            5'b11010, 5'b11100, 5'b11101, 5'b11110, 5'b11111:       last = IW'(2);
            default:                                                last = IW'(5);
        endcase
    end

    assign at_last    = state == EXEC && idx == last;
    assign instr_done = at_last && !stall && !stop;
    assign clear      = state == CLR;
    assign int_ack    = state == INT0;

    // stop outranks stall, which outranks advancing
    always_comb begin
        nstate = state;
        nidx   = idx;
        if (!stop) begin
            case (state)
                CLR: begin
                    nstate = EXEC;
                    nidx   = '0;
                end
                EXEC: if (!stall) begin
                    if (!at_last) nidx = idx + 1'b1;
                    else if (opcode == OP_HALT) nstate = HALTED;
                    else begin
                        nstate = irq ? INT0 : EXEC;
                        nidx   = '0;
                    end
                end
                INT0: if (!stall) nstate = INT1;
                INT1: if (!stall) begin
                    nstate = EXEC;
                    nidx   = '0;
                end
                HALTED: if (irq) nstate = INT0;
                    else if (resume) begin
                        nstate = EXEC;
                        nidx   = '0;
                    end
                default: nstate = CLR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLR;
            idx     <= '0;
            step    <= '0;
            int_seq <= '0;
            run     <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state   <= nstate;
            idx     <= nidx;
            step    <= (nstate == EXEC) ? STEP_COUNT'(1) << nidx : '0;
            int_seq <= {nstate == INT1, nstate == INT0};
            run     <= !stop && (nstate inside {EXEC, INT0, INT1});
            halted  <= nstate == HALTED;
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized stimulus against a cycle-level reference
// model; expectations are queued by the driver and checked by a negedge monitor.
module tb_control_sequencer;
    logic        clk = 0, reset = 0, stop = 0, stall = 0, resume = 0, int_req = 0, int_mask = 0;
    logic [31:0] IR = 0;
    logic [7:0]  step;
    logic [1:0]  int_seq;
    logic        run, clear, halted, int_ack, instr_done;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .reset(reset), .stop(stop), .stall(stall), .resume(resume), .IR(IR),
        .int_req(int_req), .int_mask(int_mask), .step(step), .int_seq(int_seq), .run(run),
        .clear(clear), .halted(halted), .int_ack(int_ack), .instr_done(instr_done)
    );

`ifdef CTRL_INTR_EN
    localparam bit INTR = 1'b1;
`else
    localparam bit INTR = 1'b0;
`endif
    localparam int M_CLR = 0, M_EXEC = 1, M_I0 = 2, M_I1 = 3, M_HALT = 4;

    typedef struct packed {
        logic [7:0] step;
        logic [1:0] iseq;
        logic       run, clr, hlt, ack, done;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          checks = 0, errors = 0;
    int          mode = M_CLR, t = 0;
    logic        run_e = 0;
    logic [4:0]  op = 5'd3;
    logic [26:0] low = 0;

    function automatic int last_of(input logic [4:0] o);
        if (o inside {5'd0, 5'd2}) return 7;
        if (o inside {5'd15, 5'd16, 5'd19}) return 6;
        if (o inside {5'd17, 5'd18, 5'd21}) return 4;
        if (o inside {5'd20, 5'd22, 5'd23, 5'd24, 5'd25, 5'd27}) return 3;
        if (o == 5'd26 || o >= 5'd28) return 2;
        return 5;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("step", step, me.step);
            chk("int_seq", {6'b0, int_seq}, {6'b0, me.iseq});
            chk("run", {7'b0, run}, {7'b0, me.run});
            chk("clear", {7'b0, clear}, {7'b0, me.clr});
            chk("halted", {7'b0, halted}, {7'b0, me.hlt});
            chk("int_ack", {7'b0, int_ack}, {7'b0, me.ack});
            chk("instr_done", {7'b0, instr_done}, {7'b0, me.done});
        end
    end

    // Drive one cycle of inputs, queue what the DUT must show, then advance the model.
    task automatic cycle(input logic rn, st, sl, rs, rq, mk);
        exp_t e;
        logic irq;
        reset = rn; stop = st; stall = sl; resume = rs; int_req = rq; int_mask = mk;
        IR = {op, low};
        if (!rn) begin
            mode = M_CLR; t = 0; run_e = 0;
        end
        e.step = (mode == M_EXEC) ? 8'(1 << t) : 8'h0;
        e.iseq = {mode == M_I1, mode == M_I0};
        e.run  = run_e;
        e.clr  = mode == M_CLR;
        e.hlt  = mode == M_HALT;
        e.ack  = mode == M_I0;
        e.done = mode == M_EXEC && t == last_of(op) && !sl && !st;
        q.push_back(e);
        @(posedge clk);
        irq = INTR && rq && !mk;
        if (rn && !st) begin
            case (mode)
                M_CLR: begin mode = M_EXEC; t = 0; end
                M_EXEC: if (!sl) begin
                    if (t < last_of(op)) t++;
                    else if (op == 5'd27) mode = M_HALT;
                    else begin
                        t = 0;
                        if (irq) mode = M_I0;
                    end
                end
                M_I0: if (!sl) mode = M_I1;
                M_I1: if (!sl) begin mode = M_EXEC; t = 0; end
                default: if (irq) mode = M_I0;
                    else if (rs) begin mode = M_EXEC; t = 0; end
            endcase
        end
        run_e = rn && !st && (mode inside {M_EXEC, M_I0, M_I1});
        #1;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        op = 5'd3;  plain(13);
        op = 5'd0;  plain(6);
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 0, 0);
        plain(2);
        op = 5'd27; plain(7);
        cycle(1, 0, 0, 1, 0, 0);
        op = 5'd26;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 1, 0, 0);
        op = 5'd17; plain(4);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 0);
        plain(1);
        op = 5'd16; plain(6);
        cycle(1, 0, 0, 0, 1, 0);
        cycle(1, 0, 1, 0, 0, 0);
        plain(8);
        cycle(1, 0, 0, 0, 1, 1);
        plain(6);
        cycle(1, 0, 0, 0, 1, 0);
        plain(1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        plain(3);
        op = 5'd27; plain(5);
        cycle(1, 0, 0, 1, 1, 0);
        plain(4);
        for (int i = 0; i < 3000; i++) begin
            if (mode != M_EXEC || t == 0) begin
                op  = 5'($urandom_range(0, 31));
                low = 27'($urandom);
            end
            cycle($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
